// File: rtl/rv64im_pkg.sv
// rtl/rv64im_pkg.sv - shared ALU control codes, muldiv state encoding and XLEN
package rv64im_pkg;

    localparam int XLEN = 64;

    // Codes 0..11 belong to the single-cycle ALU, 12..19 to the muldiv unit.
    localparam logic [4:0] ALU_AND    = 5'd0;
    localparam logic [4:0] ALU_ADD    = 5'd1;
    localparam logic [4:0] ALU_OR     = 5'd2;
    localparam logic [4:0] ALU_XOR    = 5'd3;
    localparam logic [4:0] ALU_SUB    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    localparam logic [4:0] ALU_AUIPC  = 5'd11;
    localparam logic [4:0] ALU_MUL    = 5'd12;
    localparam logic [4:0] ALU_MULH   = 5'd13;
    localparam logic [4:0] ALU_MULHSU = 5'd14;
    localparam logic [4:0] ALU_MULHU  = 5'd15;
    localparam logic [4:0] ALU_DIV    = 5'd16;
    localparam logic [4:0] ALU_DIVU   = 5'd17;
    localparam logic [4:0] ALU_REM    = 5'd18;
    localparam logic [4:0] ALU_REMU   = 5'd19;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [4:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REMU);
    endfunction

    function automatic logic op_is_div(input logic [4:0] code);
        return (code >= ALU_DIV) && (code <= ALU_REMU);
    endfunction

    function automatic logic op_a_signed(input logic [4:0] code);
        return code inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic op_b_signed(input logic [4:0] code);
        return code inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - conditional two's-complement negate (abs value / sign restore)
module muldiv_sign_fix #(
    parameter int W = 64
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] fixed_value
);

    assign fixed_value = negate ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M multiply/divide unit, one result bit per cycle
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [4:0]       alu_control,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    input  logic [TAG_W-1:0] in_rd,
    input  logic             flush,
    output logic             in_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_valid
);
    import rv64im_pkg::*;

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e state, state_next;

    logic [4:0]        op;
    logic [TAG_W-1:0]  rd_q;
    logic              sa, sb;
    logic [XLEN-1:0]   opb_mag;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  count;

    logic              a_sgn, b_sgn, neg_a, neg_b;
    logic              div_zero, div_ovf, fast, accept;
    logic [XLEN-1:0]   abs_a, abs_b, quot_fix, rem_fix, res_sel, rem_next;
    logic [2*XLEN-1:0] prod_fix, mul_next, div_next;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;

    assign in_ready = rst_n && (state == MD_IDLE);
    assign a_sgn    = op_a_signed(alu_control);
    assign b_sgn    = op_b_signed(alu_control);
    assign neg_a    = a_sgn && operand_a[XLEN-1];
    assign neg_b    = b_sgn && operand_b[XLEN-1];
    assign div_zero = op_is_div(alu_control) && (operand_b == '0);
    assign div_ovf  = op_is_div(alu_control) && a_sgn && (operand_a == MIN_NEG) && (operand_b == '1);
    assign fast     = div_zero || div_ovf;
    assign accept   = valid && in_ready && is_muldiv(alu_control) && !flush;

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (.value(operand_a), .negate(neg_a), .fixed_value(abs_a));
    muldiv_sign_fix #(.W(XLEN)) u_abs_b (.value(operand_b), .negate(neg_b), .fixed_value(abs_b));
    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (.value(acc), .negate(sa ^ sb), .fixed_value(prod_fix));
    muldiv_sign_fix #(.W(XLEN)) u_fix_quot (.value(acc[XLEN-1:0]), .negate(sa ^ sb), .fixed_value(quot_fix));
    muldiv_sign_fix #(.W(XLEN)) u_fix_rem (.value(acc[2*XLEN-1:XLEN]), .negate(sa), .fixed_value(rem_fix));

    // acc holds {high, low}: product/multiplier for multiply, remainder/quotient for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_mag} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opb_mag};
        rem_next  = div_ge ? XLEN'(div_shift - {1'b0, opb_mag}) : div_shift[XLEN-1:0];
        div_next  = {rem_next, acc[XLEN-2:0], div_ge};
    end

    always_comb begin
        res_sel = rem_fix;
        case (op)
            ALU_MUL:                         res_sel = prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: res_sel = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               res_sel = quot_fix;
            default:                         res_sel = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (accept) state_next = fast ? MD_DONE : MD_CALC;
            MD_CALC: begin
                if (flush)                              state_next = MD_IDLE;
                else if (count == CNT_W'(XLEN - 1))     state_next = MD_DONE;
            end
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            out_rd    <= '0;
            out_valid <= 1'b0;
            count     <= '0;
            op        <= '0;
            rd_q      <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            opb_mag   <= '0;
            acc       <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        op    <= alu_control;
                        rd_q  <= in_rd;
                        count <= '0;
                        if (fast) begin
                            // Final quotient/remainder loaded as-is; no sign correction applies.
                            sa  <= 1'b0;
                            sb  <= 1'b0;
                            acc <= div_zero ? {operand_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, operand_a};
                        end else begin
                            sa      <= neg_a;
                            sb      <= neg_b;
                            acc     <= {{XLEN{1'b0}}, abs_a};
                            opb_mag <= abs_b;
                        end
                    end
                end
                MD_CALC: begin
                    if (!flush) begin
                        acc   <= op_is_div(op) ? div_next : mul_next;
                        count <= count + CNT_W'(1);
                    end
                end
                MD_DONE: begin
                    if (!flush) begin
                        result    <= res_sel;
                        out_rd    <= rd_q;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, valid, flush;
    logic [4:0]       alu_control;
    logic [XLEN-1:0]  operand_a, operand_b;
    logic [TAG_W-1:0] in_rd;
    logic             in_ready, out_valid;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_rd;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .alu_control(alu_control),
        .operand_a(operand_a), .operand_b(operand_b), .in_rd(in_rd), .flush(flush),
        .in_ready(in_ready), .result(result), .out_rd(out_rd), .out_valid(out_valid)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model_res(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [127:0] ea, eb;
        ea = {{64{a[63]}}, a};
        eb = {{64{b[63]}}, b};
        case (op)
            5'd12: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
            5'd13: begin p = ea * eb; return p[127:64]; end
            5'd14: begin p = ea * {64'b0, b}; return p[127:64]; end
            5'd15: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            5'd16: begin
                if (b == 0) return ONES;
                if (a == MINV && b == ONES) return a;
                return $signed(a) / $signed(b);
            end
            5'd17: return (b == 0) ? ONES : a / b;
            5'd18: begin
                if (b == 0) return a;
                if (a == MINV && b == ONES) return 64'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit model_fast(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        return (op >= 5'd16) && ((b == 0) || ((op == 5'd16 || op == 5'd18) && a == MINV && b == ONES));
    endfunction

    // Transaction-level model: one request in flight, fixed latency, flush/reset cancel.
    logic             m_busy, m_valid;
    logic [63:0]      m_res, m_pend_res;
    logic [4:0]       m_rd, m_pend_rd;
    int               m_left;
    int unsigned      m_acc_edge;

    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_res  <= '0;
            m_rd   <= '0;
        end else if (m_busy) begin
            if (flush) begin
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_res   <= m_pend_res;
                m_rd    <= m_pend_rd;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (valid && !flush && alu_control >= 5'd12 && alu_control <= 5'd19) begin
            m_busy     <= 1'b1;
            m_pend_res <= model_res(alu_control, operand_a, operand_b);
            m_pend_rd  <= in_rd;
            m_left     <= model_fast(alu_control, operand_a, operand_b) ? 1 : XLEN + 1;
            m_acc_edge <= cyc + 1;
        end
    end

    // Hand-computed expectations, consumed in order by completed requests.
    logic [63:0] lit_res [0:31];
    logic [4:0]  lit_rdv [0:31];
    int          lit_lat [0:31];
    int          lit_ptr_w = 0;
    int          lit_ptr_r = 0;
    bit          tb_done = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("in_ready", 64'(in_ready), 64'(rst_n && !m_busy));
            check("result", result, m_res);
            check("out_rd", 64'(out_rd), 64'(m_rd));
            if (m_valid && lit_ptr_r < lit_ptr_w) begin
                check("lit_result", result, lit_res[lit_ptr_r]);
                check("model_pin", m_res, lit_res[lit_ptr_r]);
                check("lit_rd", 64'(out_rd), 64'(lit_rdv[lit_ptr_r]));
                check("lit_latency", 64'(cyc - m_acc_edge), 64'(lit_lat[lit_ptr_r]));
                lit_ptr_r++;
            end
        end
        if (tb_done) begin
            check("lit_consumed", 64'(lit_ptr_r), 64'(lit_ptr_w));
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        valid = 1'b1;
        alu_control = op;
        operand_a = a;
        operand_b = b;
        in_rd = rd;
        tick();
        valid = 1'b0;
    endtask

    task automatic expect_lit(input logic [63:0] res, input logic [4:0] rd, input int lat);
        lit_res[lit_ptr_w] = res;
        lit_rdv[lit_ptr_w] = rd;
        lit_lat[lit_ptr_w] = lat;
        lit_ptr_w++;
    endtask

    task automatic run(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] res, input int lat);
        expect_lit(res, rd, lat);
        issue(op, a, b, rd);
        repeat (lat) tick();
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0;
        alu_control = '0; operand_a = '0; operand_b = '0; in_rd = '0;
        #1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        run(5'd12, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run(5'd15, ONES, ONES, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run(5'd13, ONES, ONES, 5'd5, 64'd0, 65);
        run(5'd14, ONES, 64'd2, 5'd6, ONES, 65);
        run(5'd16, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run(5'd18, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, ONES, 65);
        run(5'd17, 64'd100, 64'd7, 5'd9, 64'd14, 65);
        run(5'd19, 64'd100, 64'd7, 5'd10, 64'd2, 65);
        run(5'd17, 64'd5, 64'd0, 5'd11, ONES, 1);
        run(5'd19, 64'd5, 64'd0, 5'd12, 64'd5, 1);
        run(5'd16, MINV, ONES, 5'd13, MINV, 1);
        run(5'd18, MINV, ONES, 5'd14, 64'd0, 1);
        tick();

        issue(5'd12, 64'd123, 64'd456, 5'd15);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (70) tick();
        run(5'd12, 64'd3, 64'd4, 5'd16, 64'd12, 65);
        tick();

        flush = 1'b1;
        issue(5'd12, 64'd5, 64'd6, 5'd17);
        flush = 1'b0;
        repeat (3) tick();

        issue(5'd12, 64'd123, 64'd456, 5'd18);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (70) tick();

        issue(5'd1, 64'd9, 64'd9, 5'd19);
        repeat (3) tick();

        expect_lit(64'd42, 5'd20, 65);
        issue(5'd12, 64'd6, 64'd7, 5'd20);
        repeat (5) tick();
        issue(5'd16, 64'd9, 64'd3, 5'd21);
        repeat (59) tick();
        run(5'd17, 64'd1000, 64'd10, 5'd22, 64'd100, 65);
        run(5'd15, MINV, 64'd4, 5'd23, 64'd2, 65);
        run(5'd19, 64'd5, 64'd0, 5'd24, 64'd5, 1);
        run(5'd12, 64'd3, 64'd4, 5'd25, 64'd12, 65);
        repeat (3) tick();
        tb_done = 1'b1;
    end

endmodule
